note_playback_sequencer: RTL and testbench
==========================================

// Module: note_playback_sequencer
// PURPOSE
//  Read-side controller for the 16-entry note memory. On start it steps note_counter through the stored notes.
//  It holds ld_play high and flags next_note_en while each note sounds.
//  It turns the datapath's freq_out (half-period in clk cycles) into a square-wave audio_out.
//  Sits beside the note datapath: drives its note_counter/ld_play/next_note_en, consumes its freq_out.
// PARAMETERS
//  BEAT_CYCLES  12_500_000  clk cycles a note sounds (250 ms @ 50 MHz)
//  GAP_CYCLES   1_250_000   silent clk cycles between notes
//  SETTLE_CYC   2           cycles from note_counter change to valid freq_in (addr reg + sync RAM)
//  FREQ_W       32          width of freq_in / half-period counter
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-low
//  start         in   1       1-cycle request to begin playback
//  stop          in   1       abort playback
//  loop_en       in   1       1: restart at note 0 after last note
//  note_count    in   5       number of stored notes, 0..16 (values >16 clamp to 16)
//  freq_in       in   FREQ_W  half-period of current note in clk cycles; 0 = rest
//  note_counter  out  4       memory address of note being played
//  ld_play       out  1       high whenever busy (datapath in read mode)
//  next_note_en  out  1       high during PLAY (highlight colour)
//  audio_out     out  1       square wave
//  busy          out  1       state != IDLE
//  done          out  1       1-cycle pulse at end of non-looped playback
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE. All outputs 0. All counters 0. Reset mid-operation aborts immediately.
//  States: IDLE, SETTLE, PLAY, GAP, DONE.
//  IDLE:
//   - start & !stop & note_count!=0: note_counter<=0, ld_play<=1, go to SETTLE.
//   - start & note_count==0: done pulses next cycle; state stays IDLE.
//   - start & stop together: stop wins, no action.
//  SETTLE: wait SETTLE_CYC cycles. On the last cycle latch freq_in into half_period and reset the tone phase (audio_out=0). Go to PLAY.
//  PLAY:
//   - next_note_en=1. Beat counter runs 0..BEAT(-1), then go to GAP.
//   - Tone: counter 0..half_period-1, toggles audio_out on wrap.
//   - half_period==0: audio_out held 0.
//  GAP: audio_out=0, next_note_en=0; wait GAP_CYCLES. At end:
//   - note_counter < N-1 (N = clamped note_count): note_counter+1, go to SETTLE.
//   - last note & loop_en: note_counter<=0, go to SETTLE.
//   - last note & !loop_en: go to DONE.
//  DONE: done=1 for exactly one cycle; ld_play, busy <= 0; note_counter<=0; go to IDLE.
//  stop in any non-IDLE state: next cycle IDLE, all outputs 0, no done pulse.
//  start while busy: ignored.
//  note_count sampled at each GAP end, so a live change takes effect at the next note boundary.
//  Per-note period = SETTLE_CYC + BEAT + GAP_CYCLES cycles. Counters are unsigned; no overflow (BEAT, GAP < 2^32).
// CONFIGURATION
//  TEMPO_ADJ_EN defined: extra input tempo_sel[1:0].
//   - BEAT = 00:BEAT_CYCLES, 01:2x, 10:BEAT_CYCLES/2, 11:4x.
//   - tempo_sel sampled on entry to PLAY only.
//  TEMPO_ADJ_EN undefined: port absent, BEAT = BEAT_CYCLES.
// STRUCTURE
//  music_pkg: state encoding localparams, NOTE_SLOTS=16, default BEAT/GAP constants, tempo_sel codes.
//  Sub-module tone_gen: loads half_period, clear input, en input; outputs the square wave.
//  Sequencer FSM + beat/gap counter in top.
// TESTING (sim params: BEAT_CYCLES=20, GAP_CYCLES=4, SETTLE_CYC=2)
//  1. note_count=3, freq_in=5, pulse start -> ld_play=1 next cycle.
//     note_counter 0,1,2 each held 26 cycles; audio_out toggles every 5 cycles only in PLAY.
//     done pulses once after 3rd GAP; then busy=0.
//  2. loop_en=1, note_count=2 -> counter 0,1,0,1; stop raised mid-PLAY -> next cycle IDLE, audio_out=0, ld_play=0, done never pulses.
//  3. note_count=0, start -> done=1 for one cycle, ld_play/busy never rise.
//  4. freq_in=0 for note 1 of 3 -> audio_out stays 0 through that PLAY; note 2 toggles again.
//  5. reset=0 mid-PLAY -> all outputs 0 at next edge. Second start pulse while busy leaves sequence unchanged.
//  6. note_count=20 -> counter 0..15 then done. With TEMPO_ADJ_EN, tempo_sel=01 -> PLAY lasts 40 cycles.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the note playback path: sequencer state encoding,
// memory depth, default timing constants and tempo selection codes.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  localparam int NOTE_SLOTS      = 16;
  localparam int DEF_BEAT_CYCLES = 12_500_000;  // 250 ms at 50 MHz
  localparam int DEF_GAP_CYCLES  = 1_250_000;
  localparam int DEF_SETTLE_CYC  = 2;           // address register + sync RAM

  // tempo_sel codes: beat length relative to BEAT_CYCLES
  localparam logic [1:0] TEMPO_1X   = 2'b00;
  localparam logic [1:0] TEMPO_2X   = 2'b01;
  localparam logic [1:0] TEMPO_HALF = 2'b10;
  localparam logic [1:0] TEMPO_4X   = 2'b11;

  // Stored note count, limited to the number of memory slots.
  function automatic logic [4:0] clamp_count(input logic [4:0] n);
    return (n > 5'(NOTE_SLOTS)) ? 5'(NOTE_SLOTS) : n;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator. load captures a new half-period and restarts the
// phase low; clear restarts the phase low; en advances the phase counter and
// toggles wave every half-period cycles. A half-period of 0 is a rest.
module tone_gen
  import music_pkg::*;
#(
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              en,
  input  logic [FREQ_W-1:0] period,
  output logic              wave
);

  localparam logic [FREQ_W-1:0] ONE = {{(FREQ_W-1){1'b0}}, 1'b1};

  logic [FREQ_W-1:0] half_period;
  logic [FREQ_W-1:0] phase_cnt;

  // Phase counter and output toggle; load/clear take priority over stepping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      half_period <= '0;
      phase_cnt   <= '0;
      wave        <= 1'b0;
    end else if (load) begin
      half_period <= period;
      phase_cnt   <= '0;
      wave        <= 1'b0;
    end else if (clear) begin
      phase_cnt <= '0;
      wave      <= 1'b0;
    end else if (en) begin
      if (half_period == '0) begin
        phase_cnt <= '0;
        wave      <= 1'b0;
      end else if (phase_cnt == half_period - ONE) begin
        phase_cnt <= '0;
        wave      <= ~wave;
      end else begin
        phase_cnt <= phase_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/note_playback_sequencer.sv
// Read-side controller for the 16-entry note memory. Steps note_counter
// through the stored notes (SETTLE -> PLAY -> GAP per note), holds ld_play
// while busy and turns freq_in into a square wave on audio_out.
// Optional build macro TEMPO_ADJ_EN adds tempo_sel[1:0], sampled on entry to
// PLAY, which scales the beat length (1x, 2x, 1/2x, 4x).
// Handshake: start and stop are level-sampled every clock with no ready
// return; start is honoured only in IDLE, stop wins over start and aborts any
// non-IDLE state on the next edge without a done pulse.
module note_playback_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int FREQ_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [4:0]        note_count,
  input  logic [FREQ_W-1:0] freq_in,
`ifdef TEMPO_ADJ_EN
  input  logic [1:0]        tempo_sel,
`endif
  output logic [3:0]        note_counter,
  output logic              ld_play,
  output logic              next_note_en,
  output logic              audio_out,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] BEAT_LEN    = 32'(BEAT_CYCLES);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] cyc_cnt;
  logic [31:0] beat_len;
  logic [4:0]  n_eff;
  logic        last_note;
  logic        load_tone;
  logic        zero_done;
  logic        wave;

  assign n_eff     = clamp_count(note_count);
  assign last_note = ({1'b0, note_counter} + 5'd1) >= n_eff;

  // Next-state logic; stop overrides every transition out of a busy state.
  always_comb begin
    state_next = state;
    load_tone  = 1'b0;
    case (state)
      ST_IDLE:   if (start && !stop && n_eff != 5'd0) state_next = ST_SETTLE;
      ST_SETTLE: if (cyc_cnt == SETTLE_LAST) begin
                   state_next = ST_PLAY;
                   load_tone  = 1'b1;
                 end
      ST_PLAY:   if (cyc_cnt == beat_len - 32'd1) state_next = ST_GAP;
      ST_GAP:    if (cyc_cnt == GAP_LAST)
                   state_next = (last_note && !loop_en) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (stop && state != ST_IDLE) begin
      state_next = ST_IDLE;
      load_tone  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Shared settle/beat/gap counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (!reset || state_next != state || state == ST_IDLE || state == ST_DONE)
      cyc_cnt <= '0;
    else
      cyc_cnt <= cyc_cnt + 32'd1;
  end

  // Note address: cleared when leaving or sitting in IDLE, advanced or
  // wrapped at the end of each gap.
  always_ff @(posedge clk) begin
    if (!reset)
      note_counter <= '0;
    else if (state_next == ST_IDLE || state == ST_IDLE)
      note_counter <= '0;
    else if (state == ST_GAP && state_next == ST_SETTLE)
      note_counter <= last_note ? 4'd0 : note_counter + 4'd1;
  end

  // Done pulse for a start request with nothing stored.
  always_ff @(posedge clk) begin
    if (!reset) zero_done <= 1'b0;
    else        zero_done <= (state == ST_IDLE) && start && !stop && (n_eff == 5'd0);
  end

`ifdef TEMPO_ADJ_EN
  // Beat length captured alongside the note frequency on entry to PLAY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_len <= BEAT_LEN;
    end else if (load_tone) begin
      case (tempo_sel)
        TEMPO_2X:   beat_len <= 32'(BEAT_CYCLES * 2);
        TEMPO_HALF: beat_len <= 32'(BEAT_CYCLES / 2);
        TEMPO_4X:   beat_len <= 32'(BEAT_CYCLES * 4);
        default:    beat_len <= BEAT_LEN;
      endcase
    end
  end
`else
  assign beat_len = BEAT_LEN;
`endif

  tone_gen #(.FREQ_W(FREQ_W)) u_tone (
    .clk    (clk),
    .reset  (reset),
    .load   (load_tone),
    .clear  (state != ST_PLAY && !load_tone),
    .en     (state == ST_PLAY),
    .period (freq_in),
    .wave   (wave)
  );

  assign busy         = (state != ST_IDLE);
  assign ld_play      = busy;
  assign next_note_en = (state == ST_PLAY);
  assign audio_out    = wave & next_note_en;
  assign done         = (state == ST_DONE) | zero_done;

endmodule

// File: tb/tb_note_playback_sequencer.sv
// Bench for note_playback_sequencer with short timing (beat 20, gap 4,
// settle 2). Stimulus pushes expected note windows and done pulses into a
// queue; a negedge monitor rebuilds the same events from the DUT pins and
// pops/compares them.
module tb_note_playback_sequencer;

  localparam int BEAT   = 20;
  localparam int GAP    = 4;
  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + BEAT + GAP;
  localparam int FREQ_W = 32;
  localparam int W      = 32;
  localparam logic [1:0] K_NOTE = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [4:0]        note_count = 5'd0;
  logic [FREQ_W-1:0] freq_in;
`ifdef TEMPO_ADJ_EN
  logic [1:0]        tempo_sel = 2'b00;
`endif
  logic [3:0]        note_counter;
  logic              ld_play, next_note_en, audio_out, busy, done;

  logic [FREQ_W-1:0] freq_tab [16];
  assign freq_in = freq_tab[note_counter];

  note_playback_sequencer #(
    .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SETTLE_CYC(SETTLE), .FREQ_W(FREQ_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .note_count   (note_count),
    .freq_in      (freq_in),
`ifdef TEMPO_ADJ_EN
    .tempo_sel    (tempo_sel),
`endif
    .note_counter (note_counter),
    .ld_play      (ld_play),
    .next_note_en (next_note_en),
    .audio_out    (audio_out),
    .busy         (busy),
    .done         (done)
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int t0 = 0;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int bad_audio = 0;
  int bad_ld = 0;

  function automatic logic [W-1:0] rec(input logic [1:0] kind, input logic [3:0] note,
                                       input int off, input int len, input int tog);
    return {kind, note, off[11:0], len[5:0], tog[7:0]};
  endfunction

  function automatic int tog_count(input int h, input int beat);
    return (h == 0) ? 0 : (beat - 1) / h;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0h expected nothing", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // Monitor: reconstruct PLAY windows and done pulses from the pins.
  logic [3:0] w_note;
  int w_off, w_len, w_tog;
  logic prev_en = 1'b0;
  logic prev_audio = 1'b0;
  always @(negedge clk) begin
    if (audio_out && !next_note_en) bad_audio++;
    if (ld_play !== busy) bad_ld++;
    if (next_note_en && !prev_en) begin
      w_note = note_counter;
      w_off  = cyc - t0;
      w_len  = 1;
      w_tog  = 0;
    end else if (next_note_en) begin
      w_len++;
      if (audio_out !== prev_audio) w_tog++;
    end else if (prev_en) begin
      sb_pop("note_window", rec(K_NOTE, w_note, w_off, w_len, w_tog));
    end
    if (done) sb_pop("done_pulse", rec(K_DONE, note_counter, cyc - t0, 0, 0));
    prev_en    = next_note_en;
    prev_audio = audio_out;
  end

  // Driver tasks.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_off(input int k);
    @(negedge clk);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic push_run(input int n, input int beat);
    for (int i = 0; i < n; i++)
      exp_q.push_back(rec(K_NOTE, 4'(i), SETTLE + (SETTLE + beat + GAP) * i, beat,
                          tog_count(int'(freq_tab[i]), beat)));
    exp_q.push_back(rec(K_DONE, 4'(n - 1), (SETTLE + beat + GAP) * n, 0, 0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_note_counter"}, W'(note_counter), 0);
    check({tag, "_ld_play"}, W'(ld_play), 0);
    check({tag, "_next_note_en"}, W'(next_note_en), 0);
    check({tag, "_audio_out"}, W'(audio_out), 0);
    check({tag, "_busy"}, W'(busy), 0);
    check({tag, "_done"}, W'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) freq_tab[i] = 5;

    // Reset.
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 reset = 1'b1;

    // 1: three notes, half-period 5.
    note_count = 5'd3;
    push_run(3, BEAT);
    pulse_start();
    wait_off(0);
    check("t1_ld_play_first", W'(ld_play), 1);
    check("t1_busy_first", W'(busy), 1);
    wait_off(3 * PER + 1);
    check("t1_busy_after", W'(busy), 0);
    check("t1_note_counter_after", W'(note_counter), 0);

    // 2: loop over two notes, stop in the fifth PLAY.
    loop_en = 1'b1;
    note_count = 5'd2;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(rec(K_NOTE, 4'(i % 2), SETTLE + PER * i, BEAT, 3));
    exp_q.push_back(rec(K_NOTE, 4'd0, SETTLE + PER * 4, 8, 1));
    pulse_start();
    wait_off(SETTLE + PER * 4 + 7);
    check("t2_audio_before_stop", W'(audio_out), 1);
    stop = 1'b1;
    wait_off(SETTLE + PER * 4 + 8);
    check_idle("t2_stop");
    stop = 1'b0;
    loop_en = 1'b0;
    repeat (30) @(negedge clk);

    // 3: empty memory, then start together with stop.
    note_count = 5'd0;
    exp_q.push_back(rec(K_DONE, 4'd0, 0, 0, 0));
    pulse_start();
    wait_off(0);
    check("t3_busy_zero", W'(busy), 0);
    check("t3_ld_play_zero", W'(ld_play), 0);
    wait_off(1);
    check("t3_done_once", W'(done), 0);
    note_count = 5'd3;
    stop = 1'b1;
    pulse_start();
    wait_off(2);
    check("t3_start_stop_busy", W'(busy), 0);
    stop = 1'b0;
    repeat (5) @(negedge clk);

    // 4: rest on note 1.
    freq_tab[0] = 3;
    freq_tab[1] = 0;
    freq_tab[2] = 4;
    push_run(3, BEAT);
    pulse_start();
    wait_off(3 * PER + 2);
    check("t4_busy_after", W'(busy), 0);

    // 5: reset mid-PLAY, then a start pulse while busy.
    for (int i = 0; i < 16; i++) freq_tab[i] = 5;
    exp_q.push_back(rec(K_NOTE, 4'd0, SETTLE, 6, 1));
    pulse_start();
    wait_off(SETTLE + 5);
    reset = 1'b0;
    wait_off(SETTLE + 6);
    check_idle("t5_reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    note_count = 5'd2;
    push_run(2, BEAT);
    pulse_start();
    wait_off(PER + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_off(2 * PER + 3);
    check("t5_busy_after", W'(busy), 0);

    // 6: note_count beyond memory depth clamps to 16.
    for (int i = 0; i < 16; i++) freq_tab[i] = FREQ_W'(i + 1);
    note_count = 5'd20;
    push_run(16, BEAT);
    pulse_start();
    wait_off(16 * PER + 2);
    check("t6_busy_after", W'(busy), 0);

`ifdef TEMPO_ADJ_EN
    // Tempo 2x: single note plays for twice the beat.
    for (int i = 0; i < 16; i++) freq_tab[i] = 5;
    tempo_sel = 2'b01;
    note_count = 5'd1;
    push_run(1, 2 * BEAT);
    pulse_start();
    wait_off(SETTLE + 2 * BEAT + GAP + 2);
    check("tempo_busy_after", W'(busy), 0);
    tempo_sel = 2'b00;
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    check("audio_outside_play", W'(bad_audio), 0);
    check("ld_play_vs_busy", W'(bad_ld), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
